// File: rtl/regfile_pkg.sv
// Shared defaults and types for the ARM register bank and its load scoreboard.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_PC_IDX = 15;

    typedef logic [DEF_DATA_W-1:0] word_t;
    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: one busy bit per register, set by a load claim and
// cleared by the load writeback port.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 3,
    parameter int PC_IDX = DEF_PC_IDX,
    parameter int BYPASS = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           claim_en,
    input  logic [ADDR_W-1:0]              claim_addr,
    input  logic                           clr_en,
    input  logic [ADDR_W-1:0]              clr_addr,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
    output logic [NUM_RD-1:0]              rd_busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Claim is applied after the clear so a same-cycle claim/clear leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (claim_en && (claim_addr != PC_A)) begin
            busy_d[claim_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A register being written back this cycle is not busy when its data is forwarded.
    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_busy[i] = busy_q[rd_addr[i]]
                         && (rd_addr[i] != PC_A)
                         && !((BYPASS != 0) && clr_en && (clr_addr == rd_addr[i]));
        end
    end

endmodule

// File: rtl/register_bank.sv
// Multi-port ARM register file: NUM_RD read ports with PC substitution, ALU and
// load write ports with bypass, load scoreboard and registered PC redirect.
module register_bank
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 3,
    parameter int PC_IDX = DEF_PC_IDX,
    parameter int BYPASS = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
    output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
    output logic [NUM_RD-1:0]              rd_busy,
    input  logic [DATA_W-1:0]              R15,
    input  logic                           we_a,
    input  logic [ADDR_W-1:0]              wa_addr,
    input  logic [DATA_W-1:0]              wd_a,
    input  logic                           we_b,
    input  logic [ADDR_W-1:0]              wb_addr,
    input  logic [DATA_W-1:0]              wd_b,
    input  logic                           claim_en,
    input  logic [ADDR_W-1:0]              claim_addr,
    output logic                           pc_wr_valid,
    output logic [DATA_W-1:0]              pc_wr_data,
    output logic                           wr_conflict
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

    logic [DATA_W-1:0] mem_rd [DEPTH];

    // The PC entry has no storage; it is supplied by the R15 input instead.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        if (g == PC_IDX) begin : g_pc
            assign mem_rd[g] = '0;
        end else begin : g_reg
            logic [DATA_W-1:0] word_q;
            logic [DATA_W-1:0] word_d;

            always_comb begin
                word_d = word_q;
                if (we_a && (wa_addr == ADDR_W'(g))) begin
                    word_d = wd_a;
                end
                if (we_b && (wb_addr == ADDR_W'(g))) begin
                    word_d = wd_b;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    word_q <= '0;
                end else begin
                    word_q <= word_d;
                end
            end

            assign mem_rd[g] = word_q;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (rd_addr[i] == PC_A) begin
                rd_data[i] = R15;
            end else if ((BYPASS != 0) && we_b && (wb_addr == rd_addr[i])) begin
                rd_data[i] = wd_b;
            end else if ((BYPASS != 0) && we_a && (wa_addr == rd_addr[i])) begin
                rd_data[i] = wd_a;
            end else begin
                rd_data[i] = mem_rd[rd_addr[i]];
            end
        end
    end

    logic              pc_wr_valid_q, pc_wr_valid_d;
    logic [DATA_W-1:0] pc_wr_data_q,  pc_wr_data_d;
    logic              wr_conflict_q, wr_conflict_d;

    // Load writeback outranks the ALU result when both target the PC.
    always_comb begin
        pc_wr_valid_d = (we_a && (wa_addr == PC_A)) || (we_b && (wb_addr == PC_A));
        pc_wr_data_d  = pc_wr_data_q;
        if (we_b && (wb_addr == PC_A)) begin
            pc_wr_data_d = wd_b;
        end else if (we_a && (wa_addr == PC_A)) begin
            pc_wr_data_d = wd_a;
        end
        wr_conflict_d = we_a && we_b && (wa_addr == wb_addr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_wr_valid_q <= 1'b0;
            pc_wr_data_q  <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            pc_wr_valid_q <= pc_wr_valid_d;
            pc_wr_data_q  <= pc_wr_data_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    assign pc_wr_valid = pc_wr_valid_q;
    assign pc_wr_data  = pc_wr_data_q;
    assign wr_conflict = wr_conflict_q;

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .PC_IDX (PC_IDX),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .clr_en     (we_b),
        .clr_addr   (wb_addr),
        .rd_addr    (rd_addr),
        .rd_busy    (rd_busy)
    );

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: one bypassing and one non-bypassing instance
// driven by the same stimulus.
module tb_register_bank;
    import regfile_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0][3:0] rd_addr;
    logic [2:0][31:0] rd_data, rd_data_nb;
    logic [2:0]      rd_busy, rd_busy_nb;
    word_t           r15;
    logic            we_a, we_b, claim_en;
    reg_addr_t       wa_addr, wb_addr, claim_addr;
    word_t           wd_a, wd_b;
    logic            pc_wr_valid, pc_wr_valid_nb;
    word_t           pc_wr_data, pc_wr_data_nb;
    logic            wr_conflict, wr_conflict_nb;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    register_bank #(.BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .R15(r15), .we_a(we_a), .wa_addr(wa_addr), .wd_a(wd_a),
        .we_b(we_b), .wb_addr(wb_addr), .wd_b(wd_b),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .pc_wr_valid(pc_wr_valid), .pc_wr_data(pc_wr_data), .wr_conflict(wr_conflict)
    );

    register_bank #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .R15(r15), .we_a(we_a), .wa_addr(wa_addr), .wd_a(wd_a),
        .we_b(we_b), .wb_addr(wb_addr), .wd_b(wd_b),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .pc_wr_valid(pc_wr_valid_nb), .pc_wr_data(pc_wr_data_nb), .wr_conflict(wr_conflict_nb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_writes();
        we_a = 1'b0; we_b = 1'b0; claim_en = 1'b0;
    endtask

    initial begin
        rst = 1'b0; r15 = 32'h0; rd_addr = '0;
        we_a = 1'b0; wa_addr = '0; wd_a = '0;
        we_b = 1'b0; wb_addr = '0; wd_b = '0;
        claim_en = 1'b0; claim_addr = '0;
        rd_addr[0] = 4'd2; rd_addr[1] = 4'd3; rd_addr[2] = 4'd4;
        #12;
        chk("reset_rd2", rd_data[0], 32'h0);
        chk("reset_busy", {29'd0, rd_busy}, 32'h0);
        chk("reset_pc_valid", {31'd0, pc_wr_valid}, 32'h0);
        chk("reset_pc_data", pc_wr_data, 32'h0);
        chk("reset_conflict", {31'd0, wr_conflict}, 32'h0);
        rst = 1'b1;
        tick();

        // ALU write to R2 with same-cycle read
        we_a = 1'b1; wa_addr = 4'd2; wd_a = 32'h12345678;
        #1;
        chk("bypass_r2", rd_data[0], 32'h12345678);
        chk("nobypass_r2_old", rd_data_nb[0], 32'h0);
        tick();
        idle_writes();
        #1;
        chk("stored_r2", rd_data[0], 32'h12345678);
        chk("stored_r2_nb", rd_data_nb[0], 32'h12345678);

        // PC substitution and redirect from port A
        r15 = 32'h00000108; rd_addr[1] = 4'd15;
        we_a = 1'b1; wa_addr = 4'd15; wd_a = 32'h00002000;
        #1;
        chk("read_pc", rd_data[1], 32'h00000108);
        chk("read_pc_nb", rd_data_nb[1], 32'h00000108);
        tick();
        idle_writes();
        chk("pc_valid_a", {31'd0, pc_wr_valid}, 32'h1);
        chk("pc_data_a", pc_wr_data, 32'h00002000);
        chk("pc_no_conflict", {31'd0, wr_conflict}, 32'h0);
        chk("pc_not_stored", rd_data[1], 32'h00000108);
        tick();
        chk("pc_valid_drop", {31'd0, pc_wr_valid}, 32'h0);

        // Back-to-back PC writes, then both ports on the PC
        we_b = 1'b1; wb_addr = 4'd15; wd_b = 32'h00003000;
        tick();
        we_b = 1'b0;
        we_a = 1'b1; wa_addr = 4'd15; wd_a = 32'h00004000;
        chk("pc_b2b_1_valid", {31'd0, pc_wr_valid}, 32'h1);
        chk("pc_b2b_1_data", pc_wr_data, 32'h00003000);
        tick();
        we_a = 1'b1; wa_addr = 4'd15; wd_a = 32'h00005000;
        we_b = 1'b1; wb_addr = 4'd15; wd_b = 32'h00006000;
        chk("pc_b2b_2_valid", {31'd0, pc_wr_valid}, 32'h1);
        chk("pc_b2b_2_data", pc_wr_data, 32'h00004000);
        tick();
        idle_writes();
        chk("pc_both_data", pc_wr_data, 32'h00006000);
        chk("pc_both_conflict", {31'd0, wr_conflict}, 32'h1);
        tick();
        chk("pc_both_valid_drop", {31'd0, pc_wr_valid}, 32'h0);
        chk("pc_both_conflict_drop", {31'd0, wr_conflict}, 32'h0);

        // Same-address conflict on R4
        we_a = 1'b1; wa_addr = 4'd4; wd_a = 32'hAAAA0000;
        we_b = 1'b1; wb_addr = 4'd4; wd_b = 32'h5555FFFF;
        #1;
        chk("conflict_bypass_r4", rd_data[2], 32'h5555FFFF);
        tick();
        idle_writes();
        #1;
        chk("conflict_pulse", {31'd0, wr_conflict}, 32'h1);
        chk("conflict_stored_r4", rd_data[2], 32'h5555FFFF);
        chk("conflict_stored_r4_nb", rd_data_nb[2], 32'h5555FFFF);
        tick();
        chk("conflict_drop", {31'd0, wr_conflict}, 32'h0);

        // Scoreboard: claim R3, then load writeback
        rd_addr[0] = 4'd3;
        claim_en = 1'b1; claim_addr = 4'd3;
        #1;
        chk("claim_not_yet", {31'd0, rd_busy[0]}, 32'h0);
        tick();
        idle_writes();
        #1;
        chk("claim_busy", {31'd0, rd_busy[0]}, 32'h1);
        chk("claim_busy_nb", {31'd0, rd_busy_nb[0]}, 32'h1);
        we_a = 1'b1; wa_addr = 4'd3; wd_a = 32'h0BADF00D;
        tick();
        idle_writes();
        #1;
        chk("alu_keeps_busy", {31'd0, rd_busy[0]}, 32'h1);
        we_b = 1'b1; wb_addr = 4'd3; wd_b = 32'hDEADBEEF;
        #1;
        chk("wb_clears_busy", {31'd0, rd_busy[0]}, 32'h0);
        chk("wb_forward_data", rd_data[0], 32'hDEADBEEF);
        chk("wb_nb_still_busy", {31'd0, rd_busy_nb[0]}, 32'h1);
        chk("wb_nb_old_data", rd_data_nb[0], 32'h0BADF00D);
        tick();
        idle_writes();
        #1;
        chk("wb_after_busy", {31'd0, rd_busy[0]}, 32'h0);
        chk("wb_after_busy_nb", {31'd0, rd_busy_nb[0]}, 32'h0);
        chk("wb_after_data_nb", rd_data_nb[0], 32'hDEADBEEF);

        // Claim and clear of R3 in the same cycle
        claim_en = 1'b1; claim_addr = 4'd3;
        we_b = 1'b1; wb_addr = 4'd3; wd_b = 32'h11111111;
        tick();
        idle_writes();
        #1;
        chk("claim_wins_busy", {31'd0, rd_busy[0]}, 32'h1);
        chk("claim_wins_data", rd_data[0], 32'h11111111);

        // Claim of the PC is ignored
        rd_addr[1] = 4'd15;
        claim_en = 1'b1; claim_addr = 4'd15;
        tick();
        idle_writes();
        #1;
        chk("claim_pc_ignored", {31'd0, rd_busy[1]}, 32'h0);

        // Reset mid-cycle discards busy bits, stored data and a pending redirect
        rd_addr[0] = 4'd2; rd_addr[1] = 4'd3; rd_addr[2] = 4'd4;
        we_a = 1'b1; wa_addr = 4'd15; wd_a = 32'h00007000;
        tick();
        idle_writes();
        chk("pre_reset_valid", {31'd0, pc_wr_valid}, 32'h1);
        chk("pre_reset_busy_r3", {31'd0, rd_busy[1]}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_rd2", rd_data[0], 32'h0);
        chk("midrst_rd2_nb", rd_data_nb[0], 32'h0);
        chk("midrst_rd4", rd_data[2], 32'h0);
        chk("midrst_busy_r3", {31'd0, rd_busy[1]}, 32'h0);
        chk("midrst_pc_valid", {31'd0, pc_wr_valid}, 32'h0);
        chk("midrst_pc_data", pc_wr_data, 32'h0);
        rst = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/register_bank.md
# register_bank

Parametrised multi-port architectural register file for the ARM core, successor to the single-write/dual-read register file. Provides NUM_RD combinational read ports with PC (R15) substitution, two write ports (ALU result and load writeback) with write-through bypass, a per-register pending-load scoreboard for load-use stall detection, and a registered PC-redirect output when an instruction targets R15. Sits between decode (read, claim) and writeback (write ports).

## Interface
Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 4, address width; depth = 2**ADDR_W
- NUM_RD, 3, number of read ports (Rn, Rm, Rs/Rd-for-store)
- PC_IDX, 15, index of the program-counter register
- BYPASS, 1, 1 = same-cycle write data visible on reads; 0 = old value read

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD×ADDR_W  read addresses
- rd_data  out  NUM_RD×DATA_W  read data (combinational)
- rd_busy  out  NUM_RD  addressed register has a pending load
- R15  in  DATA_W  current PC+8, returned for reads of PC_IDX
- we_a / wa_addr / wd_a  in  1 / ADDR_W / DATA_W  write port A (ALU result)
- we_b / wb_addr / wd_b  in  1 / ADDR_W / DATA_W  write port B (load writeback)
- claim_en / claim_addr  in  1 / ADDR_W  mark register pending (load issued)
- pc_wr_valid  out  1  one-cycle pulse: an instruction wrote R15
- pc_wr_data  out  DATA_W  new PC value, valid with pc_wr_valid
- wr_conflict  out  1  one-cycle pulse: both ports wrote the same address

## Operation
- Storage: 2**ADDR_W words; entry PC_IDX is never stored (no flops).
- Read: rd_data[i] = R15 if rd_addr[i]==PC_IDX; else, with BYPASS=1, wd_b if we_b and wb_addr match, else wd_a if we_a and wa_addr match, else stored value. BYPASS=0: stored value only.
- Write: on clk edge, we_a writes wd_a, we_b writes wd_b. Same address on both: port B wins; wr_conflict pulses next cycle.
- Write to PC_IDX (either port): storage untouched; pc_wr_valid=1 and pc_wr_data=winning data on the next cycle (port B wins if both target PC_IDX).
- Scoreboard: busy[claim_addr] set on claim_en; busy[wb_addr] cleared on we_b. Same address claimed and cleared in one cycle: claim wins (busy stays 1). Port A write does not affect busy. Claims of PC_IDX ignored.
- rd_busy[i] = busy[rd_addr[i]], except 0 when rd_addr[i]==PC_IDX, and 0 when the same-cycle we_b clears that address and BYPASS=1 (data forwarded).

## Timing
- Reset (rst low, asynchronous): all registers 0, busy all 0, pc_wr_valid 0, pc_wr_data 0, wr_conflict 0. Reset mid-operation discards pending claims and any pending PC redirect.
- Read latency 0 cycles; write visible to storage reads 1 cycle after the edge, same cycle via bypass.
- pc_wr_valid / wr_conflict: exactly one cycle high per triggering write, latency 1.
- Back-to-back writes to PC_IDX produce consecutive pc_wr_valid pulses with respective data.
- No handshake back-pressure; caller must stall on rd_busy.

## Structure
- Package regfile_pkg: DATA_W, ADDR_W, PC_IDX defaults; typedefs word_t, reg_addr_t.
- Sub-module regfile_scoreboard (busy vector, claim/clear priority, per-port busy lookup); storage, bypass muxes and PC-redirect register in register_bank.

## Test plan
- Reset: write 0x12345678 to R2, assert rst low mid-cycle -> rd_data for R2 = 0 immediately, pc_wr_valid 0.
- Write/bypass: we_a R2=0x12345678 and read R2 same cycle -> 0x12345678 (BYPASS=1), old value (BYPASS=0); next cycle 0x12345678 either way.
- Conflict: we_a R4=0xAAAA0000, we_b R4=0x5555FFFF same edge -> R4 reads 0x5555FFFF, wr_conflict pulses one cycle.
- PC: R15 input 0x00000108, read addr 15 -> 0x00000108; we_a R15=0x00002000 -> next cycle pc_wr_valid=1, pc_wr_data=0x00002000, then 0.
- Scoreboard: claim R3 -> rd_busy=1 on R3 reads; we_b R3=0xDEADBEEF -> that cycle rd_busy=0, rd_data=0xDEADBEEF; claim+clear R3 same cycle -> busy remains 1.
- Claim R15 -> rd_busy for R15 stays 0.
